// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared constants for the push-button conditioner:
//   - default debounce / auto-repeat timings for a 25.125 MHz pixel clock
//   - channel index assignments for the pong game's PMOD2 buttons
//   - helper to size the per-channel counters
// No ports (package).
// -----------------------------------------------------------------------------
package btn_pkg;

   // Timing defaults at 25.125 MHz
   localparam int DEBOUNCE_10MS_25M = 251_250;    // 10 ms
   localparam int REPEAT_200MS_25M  = 5_025_000;  // 200 ms
   localparam int REPEAT_50MS_25M   = 1_256_250;  // 50 ms

   // Button channel indices
   localparam int CH_LEFT      = 0;
   localparam int CH_RIGHT     = 1;
   localparam int CH_SCORE_RST = 2;
   localparam int CH_SPEED_LSB = 3;
   localparam int CH_SPEED_MSB = 4;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Counters must hold every terminal value without wrapping.
   function automatic int cnt_width(input int deb, input int dly, input int per);
      return $clog2(max3(deb, dly, per) + 1);
   endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// btn_conditioner_if
// Bundles the raw button pins and the conditioned button outputs.
//   btn_raw      raw pad inputs, asynchronous to clk
//   btn_level    debounced pressed state (1 = pressed)
//   btn_press    1-cycle strobe on accepted press
//   btn_release  1-cycle strobe on accepted release
//   btn_repeat   1-cycle auto-repeat strobe while held
// Modports: master = pin driver / game side, slave = conditioner.
// -----------------------------------------------------------------------------
interface btn_conditioner_if #(
   parameter int N_CH = 5
);
   logic [N_CH-1:0] btn_raw;
   logic [N_CH-1:0] btn_level;
   logic [N_CH-1:0] btn_press;
   logic [N_CH-1:0] btn_release;
   logic [N_CH-1:0] btn_repeat;

   modport master (
      output btn_raw,
      input  btn_level, btn_press, btn_release, btn_repeat
   );

   modport slave (
      input  btn_raw,
      output btn_level, btn_press, btn_release, btn_repeat
   );
endinterface

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-FF synchroniser, debounce window, press/release
// strobes and optional auto-repeat.
//   clk          pixel clock
//   rst_n        asynchronous active-low reset
//   pin          polarity-normalised raw input (1 = pressed), asynchronous
//   level        debounced pressed state
//   press_stb    1-cycle strobe when a press is accepted
//   release_stb  1-cycle strobe when a release is accepted
//   repeat_stb   1-cycle auto-repeat strobe while held (0 if REPEAT_EN = 0)
// -----------------------------------------------------------------------------
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYC  = DEBOUNCE_10MS_25M,
   parameter int REPEAT_DELAY  = REPEAT_200MS_25M,
   parameter int REPEAT_PERIOD = REPEAT_50MS_25M,
   parameter bit REPEAT_EN     = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pin,
   output logic level,
   output logic press_stb,
   output logic release_stb,
   output logic repeat_stb
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD);

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;
   logic             st;
   logic             press_p2;
   logic             release_p2;
   logic [CNT_W-1:0] rc;
   logic             rep_phase;
   logic             repeat_p2;
   logic             accept;
   logic [CNT_W-1:0] rep_limit;

   // A change of the synced input survived a full debounce window this cycle.
   assign accept    = (sync_p1 != st) && (cnt == DEB_LAST);
   // First repeat waits the long delay, later ones the short period.
   assign rep_limit = rep_phase ? PER_LAST : DLY_LAST;

   // ---- stage p0/p1: synchroniser (reset value 0 = not pressed) ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= pin;
         sync_p1 <= sync_p0;
      end
   end

   // ---- stage p2: debounce window, stable state and edge strobes ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         st         <= 1'b0;
         press_p2   <= 1'b0;
         release_p2 <= 1'b0;
      end else begin
         press_p2   <= 1'b0;
         release_p2 <= 1'b0;
         if (sync_p1 == st) begin
            cnt <= '0;
         end else if (accept) begin
            st         <= sync_p1;
            cnt        <= '0;
            press_p2   <= sync_p1;
            release_p2 <= ~sync_p1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // ---- stage p2: auto-repeat, runs only while the stable state is held ----
   // The accept cycle clears the counter in both directions: on a press the
   // delay starts from zero, on a release no strobe may follow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rc        <= '0;
         rep_phase <= 1'b0;
         repeat_p2 <= 1'b0;
      end else begin
         repeat_p2 <= 1'b0;
         if (!REPEAT_EN || !st || accept) begin
            rc        <= '0;
            rep_phase <= 1'b0;
         end else if (rc == rep_limit) begin
            rc        <= '0;
            rep_phase <= 1'b1;
            repeat_p2 <= 1'b1;
         end else begin
            rc <= rc + 1'b1;
         end
      end
   end

   assign level       = st;
   assign press_stb   = press_p2;
   assign release_stb = release_p2;
   assign repeat_stb  = repeat_p2;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Conditions raw PMOD push-buttons for the pong/VGA game core: per channel
// synchronisation, debounce, press/release strobes and masked auto-repeat.
//   clk    pixel-domain clock (25.125 MHz)
//   rst_n  asynchronous active-low reset
//   bus    btn_conditioner_if.slave
//            btn_raw (in), btn_level / btn_press / btn_release / btn_repeat (out)
// All outputs are synchronous and active-high.
// -----------------------------------------------------------------------------
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int              N_CH          = 5,
   parameter bit              ACTIVE_LOW    = 1'b1,
   parameter int              DEBOUNCE_CYC  = DEBOUNCE_10MS_25M,
   parameter int              REPEAT_DELAY  = REPEAT_200MS_25M,
   parameter int              REPEAT_PERIOD = REPEAT_50MS_25M,
   parameter logic [N_CH-1:0] REPEAT_MASK   = N_CH'(5'b00011)
) (
   input  logic               clk,
   input  logic               rst_n,
   btn_conditioner_if.slave   bus
);

   if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
      $error("btn_conditioner: DEBOUNCE_CYC, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
   end

   logic [N_CH-1:0] pressed_raw;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] press;
   logic [N_CH-1:0] rel;
   logic [N_CH-1:0] rep;

   // Normalising before the synchroniser lets the sync flops reset to 0,
   // which is the inactive pin level seen through the inversion.
   assign pressed_raw = ACTIVE_LOW ? ~bus.btn_raw : bus.btn_raw;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYC  (DEBOUNCE_CYC),
         .REPEAT_DELAY  (REPEAT_DELAY),
         .REPEAT_PERIOD (REPEAT_PERIOD),
         .REPEAT_EN     (REPEAT_MASK[i])
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .pin         (pressed_raw[i]),
         .level       (level[i]),
         .press_stb   (press[i]),
         .release_stb (rel[i]),
         .repeat_stb  (rep[i])
      );
   end

   assign bus.btn_level   = level;
   assign bus.btn_press   = press;
   assign bus.btn_release = rel;
   assign bus.btn_repeat  = rep;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
// Directed bench for btn_conditioner with short timings
// (DEBOUNCE_CYC=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, active-low pins).
// Edge k counts rising clock edges after the pin change; outputs are
// sampled on the falling edge following edge k.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;
   import btn_pkg::*;

   localparam int N     = 5;
   localparam int DEB   = 4;
   localparam int DLY   = 10;
   localparam int PER   = 3;
   localparam int T_LVL = DEB + 2;       // edge at which level/press appear
   localparam int T_REP = T_LVL + DLY;   // edge of first repeat strobe
   localparam logic [N-1:0] MASK = 5'b00011;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   btn_conditioner_if #(.N_CH(N)) bus ();

   btn_conditioner #(
      .N_CH          (N),
      .ACTIVE_LOW    (1'b1),
      .DEBOUNCE_CYC  (DEB),
      .REPEAT_DELAY  (DLY),
      .REPEAT_PERIOD (PER),
      .REPEAT_MASK   (MASK)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [N-1:0] l, input logic [N-1:0] p,
                          input logic [N-1:0] r, input logic [N-1:0] rp);
      chk({tag, "/level"},   bus.btn_level,   l);
      chk({tag, "/press"},   bus.btn_press,   p);
      chk({tag, "/release"}, bus.btn_release, r);
      chk({tag, "/repeat"},  bus.btn_repeat,  rp);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Press channel ch now, release it after edge rel_k, observe edges 1..last_k.
   task automatic hold_cycle(input int ch, input int rel_k, input int last_k, input string tag);
      logic [N-1:0] b;
      logic         lvl;
      logic         rp;
      b = 5'b00001 << ch;
      bus.btn_raw[ch] = 1'b0;
      for (int k = 1; k <= last_k; k++) begin
         tick();
         lvl = (k >= T_LVL) && (k < rel_k + T_LVL);
         rp  = MASK[ch] && (k >= T_REP) && (k < rel_k + T_LVL) && (((k - T_REP) % PER) == 0);
         chk_all($sformatf("%s@%0d", tag, k),
                 lvl ? b : '0,
                 (k == T_LVL) ? b : '0,
                 (k == rel_k + T_LVL) ? b : '0,
                 rp ? b : '0);
         if (k == rel_k) bus.btn_raw[ch] = 1'b1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] bounce;
      bus.btn_raw = 5'b11111;
      rst_n       = 1'b0;

      // Reset held, then released with all pins idle: silent for 50 cycles.
      repeat (3) tick();
      chk_all("in_reset", '0, '0, '0, '0);
      rst_n = 1'b1;
      for (int c = 0; c < 50; c++) begin
         tick();
         chk_all($sformatf("idle@%0d", c), '0, '0, '0, '0);
      end

      // ch0: press, hold past several repeats, release at edge 36.
      hold_cycle(CH_LEFT, 36, 44, "ch0_hold");

      // ch0 bounce: raw 0,1,0,0,1 then steady 0; accepted at edge 11.
      bounce = 5'b10010;   // bounce[m-1] is the raw value before edge m
      for (int m = 1; m <= 12; m++) begin
         bus.btn_raw[CH_LEFT] = (m <= 5) ? bounce[m-1] : 1'b0;
         tick();
         chk_all($sformatf("ch0_bounce@%0d", m),
                 (m >= 11) ? 5'b00001 : 5'b00000,
                 (m == 11) ? 5'b00001 : 5'b00000,
                 5'b00000, 5'b00000);
      end
      bus.btn_raw[CH_LEFT] = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         tick();
         chk_all($sformatf("ch0_unbounce@%0d", j),
                 (j < T_LVL) ? 5'b00001 : 5'b00000,
                 5'b00000,
                 (j == T_LVL) ? 5'b00001 : 5'b00000,
                 5'b00000);
      end

      // ch2 has repeat masked off.
      hold_cycle(CH_SCORE_RST, 30, 38, "ch2_hold");

      // ch1 held, then reset asserted mid-hold.
      hold_cycle(CH_RIGHT, 1000, 20, "ch1_hold");
      rst_n = 1'b0;
      #1;
      chk_all("rst_async", '0, '0, '0, '0);
      bus.btn_raw = 5'b11111;
      repeat (3) tick();
      chk_all("rst_held", '0, '0, '0, '0);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk_all($sformatf("post_rst@%0d", c), '0, '0, '0, '0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
